// File: rtl/screen_pkg.sv
// Shared types and request-legality helper for the screen sequencer.
package screen_pkg;

    typedef enum logic [1:0] {
        Menu = 2'd0,
        Play = 2'd1,
        Over = 2'd2
    } screen_t;

    typedef enum logic [1:0] {
        Show,
        FadeOut,
        FadeIn
    } fade_state_t;

    // Wide enough for level values 0..16.
    localparam int unsigned LevelW = 5;

    function automatic logic req_legal(input screen_t cur, input screen_t dest);
        logic ok;
        ok = 1'b0;
        case (dest)
            Play:    ok = (cur == Menu);
            Over:    ok = (cur == Play);
            Menu:    ok = (cur == Play) || (cur == Over);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rgb_fade_scale.sv
// Scales each 4-bit colour channel by level / FADE_FRAMES (combinational).
module rgb_fade_scale
    import screen_pkg::*;
#(
    parameter int unsigned FADE_FRAMES = 8
) (
    input  logic [11:0]       rgb,
    input  logic [LevelW-1:0] level,
    output logic [11:0]       scaled
);

    localparam int unsigned Shift = $clog2(FADE_FRAMES);

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [8:0] prod;
        assign prod = {5'd0, rgb[i*4 +: 4]} * {4'd0, level};
        assign scaled[i*4 +: 4] = 4'(prod >> Shift);
    end

endmodule

// File: rtl/screen_sequencer.sv
// Selects the active full-screen layer, sequences frame-aligned fade-out/fade-in
// transitions and provides the single registered RGB stage to the VGA pins.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int unsigned FADE_FRAMES = 8,
    parameter int unsigned V_ACTIVE    = 480
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        start_req,
    input  logic        game_over,
    input  logic        menu_req,
    input  logic [11:0] menu_rgb,
    input  logic [11:0] play_rgb,
    input  logic [11:0] over_rgb,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic [1:0]  screen,
    output logic        busy
);

    localparam logic [LevelW-1:0] LevelFull = LevelW'(FADE_FRAMES);
    localparam logic [LevelW-1:0] LevelLast = LevelW'(FADE_FRAMES - 1);
    localparam logic [LevelW-1:0] LevelOne  = LevelW'(1);

    logic              tick_q;
    screen_t           cur_q, cur_d;
    screen_t           target_q, target_d;
    fade_state_t       state_q, state_d;
    logic              pending_q, pending_d;
    logic [LevelW-1:0] level_q, level_d;
    logic [11:0]       rgb_q;
    logic [11:0]       src;
    logic [11:0]       scaled;

    logic              req_valid;
    screen_t           req_dest;

    // Highest-priority request that is legal from the current screen.
    always_comb begin
        req_valid = 1'b0;
        req_dest  = Menu;
        if (game_over && req_legal(cur_q, Over)) begin
            req_valid = 1'b1;
            req_dest  = Over;
        end else if (menu_req && req_legal(cur_q, Menu)) begin
            req_valid = 1'b1;
            req_dest  = Menu;
        end else if (start_req && req_legal(cur_q, Play)) begin
            req_valid = 1'b1;
            req_dest  = Play;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        cur_d     = cur_q;
        pending_d = pending_q;
        target_d  = target_q;
        unique case (state_q)
            Show: begin
                if (tick_q && pending_q) begin
                    pending_d = 1'b0;
                    level_d   = level_q - LevelOne;
                    // With a single-frame fade the black frame follows immediately.
                    if (level_q == LevelOne) begin
                        cur_d   = target_q;
                        state_d = FadeIn;
                    end else begin
                        state_d = FadeOut;
                    end
                end else if (!pending_q && req_valid) begin
                    pending_d = 1'b1;
                    target_d  = req_dest;
                end
            end
            FadeOut: begin
                if (tick_q) begin
                    level_d = level_q - LevelOne;
                    if (level_q == LevelOne) begin
                        cur_d   = target_q;
                        state_d = FadeIn;
                    end
                end
            end
            FadeIn: begin
                if (tick_q) begin
                    level_d = level_q + LevelOne;
                    if (level_q == LevelLast) begin
                        state_d = Show;
                    end
                end
            end
            default: begin
                state_d = Show;
                level_d = LevelFull;
            end
        endcase
    end

    always_comb begin
        src = '0;
        unique case (cur_q)
            Menu:    src = menu_rgb;
            Play:    src = play_rgb;
            Over:    src = over_rgb;
            default: src = '0;
        endcase
    end

    rgb_fade_scale #(
        .FADE_FRAMES(FADE_FRAMES)
    ) u_scale (
        .rgb    (src),
        .level  (level_q),
        .scaled (scaled)
    );

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            tick_q    <= 1'b0;
            cur_q     <= Menu;
            target_q  <= Menu;
            state_q   <= Show;
            pending_q <= 1'b0;
            level_q   <= LevelFull;
            rgb_q     <= '0;
        end else begin
            tick_q    <= (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
            cur_q     <= cur_d;
            target_q  <= target_d;
            state_q   <= state_d;
            pending_q <= pending_d;
            level_q   <= level_d;
            rgb_q     <= blank ? scaled : 12'h000;
        end
    end

    assign red    = rgb_q[11:8];
    assign green  = rgb_q[7:4];
    assign blue   = rgb_q[3:0];
    assign screen = cur_q;
    assign busy   = (state_q != Show);

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer on a shrunken 16x12 raster, with a
// FADE_FRAMES=8 instance and a FADE_FRAMES=1 instance.
module tb_screen_sequencer;

    localparam int H_TOTAL  = 16;
    localparam int H_ACTIVE = 12;
    localparam int V_TOTAL  = 12;
    localparam int V_ACT    = 8;

    logic        vga_clk = 1'b0;
    logic        reset, reset1;
    logic [9:0]  DrawX, DrawY;
    logic        blank, start_req, game_over, menu_req;
    logic [11:0] menu_rgb, play_rgb, over_rgb;
    logic [3:0]  r8, g8, b8, r1, g1, b1;
    logic [1:0]  scr8, scr1;
    logic        busy8, busy1;
    logic        sel;

    always #5 vga_clk = ~vga_clk;

    screen_sequencer #(.FADE_FRAMES(8), .V_ACTIVE(V_ACT)) dut8 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .start_req(start_req), .game_over(game_over), .menu_req(menu_req),
        .menu_rgb(menu_rgb), .play_rgb(play_rgb), .over_rgb(over_rgb),
        .red(r8), .green(g8), .blue(b8), .screen(scr8), .busy(busy8)
    );

    screen_sequencer #(.FADE_FRAMES(1), .V_ACTIVE(V_ACT)) dut1 (
        .vga_clk(vga_clk), .reset(reset1), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .start_req(start_req), .game_over(game_over), .menu_req(menu_req),
        .menu_rgb(menu_rgb), .play_rgb(play_rgb), .over_rgb(over_rgb),
        .red(r1), .green(g1), .blue(b1), .screen(scr1), .busy(busy1)
    );

    logic [11:0] out_rgb;
    logic [1:0]  out_scr;
    logic        out_busy;
    assign out_rgb  = sel ? {r1, g1, b1} : {r8, g8, b8};
    assign out_scr  = sel ? scr1 : scr8;
    assign out_busy = sel ? busy1 : busy8;

    int vec_cnt = 0;
    int err_cnt = 0;
    int gx = 0;
    int gy = 0;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [11:0] rgb;
        logic        blank;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h (x=%0d y=%0d t=%0t)", name, act, exp, gx, gy,
                     $time);
        end
    endtask

    function automatic logic [11:0] scale(input logic [11:0] c, input int lvl, input int ff);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) r[i*4 +: 4] = 4'((int'(c[i*4 +: 4]) * lvl) / ff);
        return r;
    endfunction

    function automatic logic [11:0] src_of(input logic [1:0] s);
        case (s)
            2'd0:    return menu_rgb;
            2'd1:    return play_rgb;
            2'd2:    return over_rgb;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic active(input int x, input int y);
        return (x < H_ACTIVE) && (y < V_ACT);
    endfunction

    // One clock: pop the expectation pushed for the pixel just clocked in, then
    // advance the raster and drop any one-cycle request pulses.
    task automatic cyc();
        sb_t e;
        @(posedge vga_clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, int'(out_rgb), int'(e.exp));
        end
        start_req = 1'b0;
        game_over = 1'b0;
        menu_req  = 1'b0;
        gx++;
        if (gx == H_TOTAL) begin
            gx = 0;
            gy++;
            if (gy == V_TOTAL) gy = 0;
        end
        DrawX = 10'(gx);
        DrawY = 10'(gy);
        blank = active(gx, gy);
    endtask

    task automatic push(input string name, input logic [11:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drive_pixel(input int ff, input int lvl, input logic [1:0] scr);
        push("pixel", blank ? scale(src_of(scr), lvl, ff) : 12'h000);
        cyc();
    endtask

    task automatic finish_frame();
        while (!(gx == 0 && gy == 0)) cyc();
    endtask

    // Runs one whole frame from (0,0), checking every pixel, optionally pulsing
    // {game_over, menu_req, start_req} at (req_x, req_row).
    task automatic run_frame(input int ff, input int lvl, input logic [1:0] scr, input logic bsy,
                             input int req_row, input int req_x, input logic [2:0] req);
        check("screen", int'(out_scr), int'(scr));
        check("busy", int'(out_busy), int'(bsy));
        for (int n = 0; n < H_TOTAL * V_TOTAL; n++) begin
            if (gy == req_row && gx == req_x) {game_over, menu_req, start_req} = req;
            drive_pixel(ff, lvl, scr);
        end
    endtask

    // Frame k is the frame after the k-th tick of the fade.
    task automatic fade(input int ff, input logic [1:0] old_s, input logic [1:0] new_s,
                        input int req_k, input logic [2:0] req);
        int lvl;
        for (int k = 1; k <= 2 * ff; k++) begin
            lvl = (k <= ff) ? ff - k : k - ff;
            run_frame(ff, lvl, (k >= ff) ? new_s : old_s, k < 2 * ff,
                      (k == req_k) ? 2 : -1, 3, req);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{rgb: 12'hF80, blank: 1'b1, exp: 12'hF80};
        tbl[1] = '{rgb: 12'hF80, blank: 1'b0, exp: 12'h000};
        tbl[2] = '{rgb: 12'h123, blank: 1'b1, exp: 12'h123};
        tbl[3] = '{rgb: 12'hFFF, blank: 1'b1, exp: 12'hFFF};
        tbl[4] = '{rgb: 12'h000, blank: 1'b1, exp: 12'h000};
        tbl[5] = '{rgb: 12'hA5C, blank: 1'b0, exp: 12'h000};
        tbl[6] = '{rgb: 12'hA5C, blank: 1'b1, exp: 12'hA5C};
        tbl[7] = '{rgb: 12'h7E1, blank: 1'b1, exp: 12'h7E1};

        sel       = 1'b0;
        reset     = 1'b1;
        reset1    = 1'b1;
        start_req = 1'b0;
        game_over = 1'b0;
        menu_req  = 1'b0;
        DrawX     = 10'd0;
        DrawY     = 10'd0;
        blank     = 1'b1;
        menu_rgb  = 12'hF80;
        play_rgb  = 12'h0F0;
        over_rgb  = 12'h00F;

        repeat (3) cyc();
        check("rst_rgb", int'(out_rgb), 0);
        check("rst_screen", int'(out_scr), 0);
        check("rst_busy", int'(out_busy), 0);
        reset = 1'b0;
        finish_frame();

        // Pass-through and blanking at full level on the menu screen.
        for (int i = 0; i < 8; i++) begin
            menu_rgb = tbl[i].rgb;
            blank    = tbl[i].blank;
            push("table", tbl[i].exp);
            cyc();
        end
        finish_frame();
        menu_rgb = 12'hF80;
        repeat (2) run_frame(8, 8, 2'd0, 1'b0, -1, 3, 3'b000);

        // game_over is illegal in MENU.
        run_frame(8, 8, 2'd0, 1'b0, 2, 3, 3'b100);
        repeat (3) run_frame(8, 8, 2'd0, 1'b0, -1, 3, 3'b000);

        // MENU -> PLAY; requests pulsed mid-fade must be ignored.
        menu_rgb = 12'hFFF;
        play_rgb = 12'h8F4;
        over_rgb = 12'h3C9;
        run_frame(8, 8, 2'd0, 1'b0, 2, 3, 3'b001);
        fade(8, 2'd0, 2'd1, 10, 3'b011);
        repeat (2) run_frame(8, 8, 2'd1, 1'b0, -1, 3, 3'b000);

        // game_over beats menu_req.
        run_frame(8, 8, 2'd1, 1'b0, 2, 3, 3'b110);
        fade(8, 2'd1, 2'd2, -1, 3'b000);
        run_frame(8, 8, 2'd2, 1'b0, -1, 3, 3'b000);

        // Request coincident with the frame tick: latched, fade waits one frame.
        run_frame(8, 8, 2'd2, 1'b0, V_ACT, 1, 3'b010);
        run_frame(8, 8, 2'd2, 1'b0, -1, 3, 3'b000);
        for (int k = 1; k <= 4; k++) run_frame(8, 8 - k, 2'd2, 1'b1, -1, 3, 3'b000);

        // Reset during FADE_OUT at level 3.
        check("screen", int'(out_scr), 2);
        check("busy", int'(out_busy), 1);
        while (!(gy == 2 && gx == 5)) drive_pixel(8, 3, 2'd2);
        reset = 1'b1;
        #1;
        check("midrst_rgb", int'(out_rgb), 0);
        check("midrst_screen", int'(out_scr), 0);
        check("midrst_busy", int'(out_busy), 0);
        repeat (2) cyc();
        reset = 1'b0;
        finish_frame();
        repeat (2) run_frame(8, 8, 2'd0, 1'b0, -1, 3, 3'b000);

        // Single-frame fades: MENU -> PLAY -> OVER -> MENU.
        sel    = 1'b1;
        reset1 = 1'b0;
        run_frame(1, 1, 2'd0, 1'b0, 2, 3, 3'b001);
        fade(1, 2'd0, 2'd1, 2, 3'b100);
        fade(1, 2'd1, 2'd2, 2, 3'b010);
        fade(1, 2'd2, 2'd0, -1, 3'b000);
        run_frame(1, 1, 2'd0, 1'b0, -1, 3, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
